// File: rtl/umi_decode_pipe_if.sv
// Bus interface for umi_decode_pipe.
// Carries the input command handshake and the decoded output handshake.
//   in_valid/in_cmd/in_ready : command input, valid/ready
//   out_valid/out_ready      : decoded entry output, valid/ready
//   out_write..out_illegal   : one-hot class flags of the head entry
//   out_opcode/out_length/out_user : command fields of the head entry
// Modports: master = command source / result sink, slave = the decoder.
interface umi_decode_pipe_if #(
    parameter int unsigned CW = 32
);
    logic           in_valid;
    logic [CW-1:0]  in_cmd;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic           out_write;
    logic           out_write_signal;
    logic           out_write_ack;
    logic           out_read;
    logic [6:0]     out_atomic;
    logic           out_illegal;
    logic [7:0]     out_opcode;
    logic [3:0]     out_length;
    logic [CW-13:0] out_user;

    modport master (
        output in_valid, in_cmd, out_ready,
        input  in_ready, out_valid, out_write, out_write_signal, out_write_ack,
               out_read, out_atomic, out_illegal, out_opcode, out_length, out_user
    );

    modport slave (
        input  in_valid, in_cmd, out_ready,
        output in_ready, out_valid, out_write, out_write_signal, out_write_ack,
               out_read, out_atomic, out_illegal, out_opcode, out_length, out_user
    );
endinterface

// File: rtl/umi_decode_pipe.sv
// Pipelined, flow-controlled UMI command decoder.
// Decodes each accepted command into one-hot class flags plus opcode/length/user fields and
// presents the result through a 2-entry in-order buffer. Keeps saturating class counters.
// Ports:
//   clk, reset  : clock; asynchronous active-high reset
//   bus         : umi_decode_pipe_if.slave (command in, decoded entry out)
//   cnt_clear   : synchronous clear of all counters (wins over increment)
//   cnt_write   : forwarded write-class transfers (write, write_signal, write_ack)
//   cnt_read    : forwarded read transfers
//   cnt_atomic  : forwarded atomic transfers
//   cnt_illegal : illegal commands accepted at the input
module umi_decode_pipe #(
    parameter int unsigned CW           = 32,
    parameter int unsigned CNTW         = 16,
    parameter bit          DROP_ILLEGAL = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    umi_decode_pipe_if.slave bus,
    input  logic            cnt_clear,
    output logic [CNTW-1:0] cnt_write,
    output logic [CNTW-1:0] cnt_read,
    output logic [CNTW-1:0] cnt_atomic,
    output logic [CNTW-1:0] cnt_illegal
);
    typedef struct packed {
        logic [CW-13:0] user;
        logic [3:0]     length;
        logic [7:0]     opcode;
        logic           illegal;
        logic [6:0]     atomic;   // {max,min,swap,xor,or,and,add}
        logic           read;
        logic           write_ack;
        logic           write_signal;
        logic           write;
    } entry_t;

    entry_t      dec;
    entry_t      head;
    entry_t      mem_q [2];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q;
    logic        accept, push, pop;
    logic        pop_write, pop_read, pop_atomic;

    always_comb begin
        dec        = '0;
        dec.opcode = bus.in_cmd[7:0];
        dec.length = bus.in_cmd[11:8];
        dec.user   = bus.in_cmd[CW-1:12];
        case (bus.in_cmd[7:0])
            8'h01:   dec.write        = 1'b1;
            8'h03:   dec.write_signal = 1'b1;
            8'h05:   dec.write_ack    = 1'b1;
            8'h08:   dec.read         = 1'b1;
            8'h09:   dec.atomic       = 7'b0000001;
            8'h19:   dec.atomic       = 7'b0000010;
            8'h29:   dec.atomic       = 7'b0000100;
            8'h39:   dec.atomic       = 7'b0001000;
            8'h49:   dec.atomic       = 7'b0010000;
            8'h59:   dec.atomic       = 7'b0100000;
            8'h69:   dec.atomic       = 7'b1000000;
            default: dec.illegal      = 1'b1;
        endcase
    end

    // accept gates everything, so an X command while idle never reaches state
    assign accept  = bus.in_valid & in_ready_q;
    assign push    = accept & ~(DROP_ILLEGAL & dec.illegal);
    assign pop     = bus.out_valid & bus.out_ready;
    assign count_d = count_q + {1'b0, push} - {1'b0, pop};
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= dec;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            in_ready_q <= (count_d < 2'd2);
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.out_valid        = (count_q != 2'd0);
    assign bus.out_write        = head.write;
    assign bus.out_write_signal = head.write_signal;
    assign bus.out_write_ack    = head.write_ack;
    assign bus.out_read         = head.read;
    assign bus.out_atomic       = head.atomic;
    assign bus.out_illegal      = head.illegal;
    assign bus.out_opcode       = head.opcode;
    assign bus.out_length       = head.length;
    assign bus.out_user         = head.user;

    assign pop_write  = pop & (head.write | head.write_signal | head.write_ack);
    assign pop_read   = pop & head.read;
    assign pop_atomic = pop & (|head.atomic);

    function automatic logic [CNTW-1:0] sat_next(input logic [CNTW-1:0] cnt, input logic inc,
                                                 input logic clr);
        if (clr) begin
            return '0;
        end else if (inc && (cnt != {CNTW{1'b1}})) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_write   <= '0;
            cnt_read    <= '0;
            cnt_atomic  <= '0;
            cnt_illegal <= '0;
        end else begin
            cnt_write   <= sat_next(cnt_write, pop_write, cnt_clear);
            cnt_read    <= sat_next(cnt_read, pop_read, cnt_clear);
            cnt_atomic  <= sat_next(cnt_atomic, pop_atomic, cnt_clear);
            cnt_illegal <= sat_next(cnt_illegal, accept & dec.illegal, cnt_clear);
        end
    end
endmodule

// File: tb/tb_umi_decode_pipe.sv
// Self-checking bench for umi_decode_pipe.
// Three instances share clock, reset and stimulus: main (DROP_ILLEGAL=0, CNTW=16),
// drop (DROP_ILLEGAL=1) and sat (CNTW=4). Outputs are sampled on the falling edge.
module tb_umi_decode_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cnt_clear = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    umi_decode_pipe_if #(.CW(32)) bm ();
    umi_decode_pipe_if #(.CW(32)) bd ();
    umi_decode_pipe_if #(.CW(32)) bs ();

    logic [15:0] m_cw, m_cr, m_ca, m_ci;
    logic [15:0] d_cw, d_cr, d_ca, d_ci;
    logic [3:0]  s_cw, s_cr, s_ca, s_ci;

    umi_decode_pipe #(.CW(32), .CNTW(16), .DROP_ILLEGAL(1'b0)) dut (
        .clk(clk), .reset(reset), .bus(bm), .cnt_clear(cnt_clear),
        .cnt_write(m_cw), .cnt_read(m_cr), .cnt_atomic(m_ca), .cnt_illegal(m_ci)
    );
    umi_decode_pipe #(.CW(32), .CNTW(16), .DROP_ILLEGAL(1'b1)) dut_drop (
        .clk(clk), .reset(reset), .bus(bd), .cnt_clear(cnt_clear),
        .cnt_write(d_cw), .cnt_read(d_cr), .cnt_atomic(d_ca), .cnt_illegal(d_ci)
    );
    umi_decode_pipe #(.CW(32), .CNTW(4), .DROP_ILLEGAL(1'b0)) dut_sat (
        .clk(clk), .reset(reset), .bus(bs), .cnt_clear(cnt_clear),
        .cnt_write(s_cw), .cnt_read(s_cr), .cnt_atomic(s_ca), .cnt_illegal(s_ci)
    );

    task automatic drive(input logic v, input logic [31:0] cmd, input logic rdy);
        bm.in_valid = v; bm.in_cmd = cmd; bm.out_ready = rdy;
        bd.in_valid = v; bd.in_cmd = cmd; bd.out_ready = rdy;
        bs.in_valid = v; bs.in_cmd = cmd; bs.out_ready = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 'x, 1'b0);
        cnt_clear = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 'x, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bm.out_valid !== 1'b0 || bm.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b, need 0 0", bm.out_valid, bm.in_ready);
        end
        checks++;
        if ({bm.out_write, bm.out_write_signal, bm.out_write_ack, bm.out_read, bm.out_atomic,
             bm.out_illegal, bm.out_opcode, bm.out_length, bm.out_user} !== '0) begin
            errors++;
            $display("FAIL reset_fields: opcode=%h illegal=%b user=%h, need all 0",
                     bm.out_opcode, bm.out_illegal, bm.out_user);
        end
        checks++;
        if ({m_cw, m_cr, m_ca, m_ci} !== 64'd0) begin
            errors++;
            $display("FAIL reset_cnt: %0d %0d %0d %0d, need 0", m_cw, m_cr, m_ca, m_ci);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bm.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_ready: in_ready=%b before first edge, need 0", bm.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bm.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_rise: in_ready=%b after first edge, need 1", bm.in_ready);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 32'h0012_3401, 1'b1);
        @(negedge clk);
        drive(1'b0, 'x, 1'b1);
        checks++;
        if (bm.out_valid !== 1'b1 || bm.out_write !== 1'b1 || bm.out_length !== 4'd4 ||
            bm.out_user !== 20'h00123 || bm.out_opcode !== 8'h01 || bm.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL single_decode: v=%b wr=%b len=%h user=%h op=%h ill=%b, need 1 1 4 00123 01 0",
                     bm.out_valid, bm.out_write, bm.out_length, bm.out_user, bm.out_opcode,
                     bm.out_illegal);
        end
        @(negedge clk);
        checks++;
        if (m_cw !== 16'd1 || bm.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_cnt: cnt_write=%0d out_valid=%b, need 1 0", m_cw, bm.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 32'h0000_0008, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h0000_0019, 1'b0);
        checks++;
        if (bm.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready1: in_ready=%b with 1 entry, need 1", bm.in_ready);
        end
        @(negedge clk);
        drive(1'b1, 32'h0000_0005, 1'b0);
        checks++;
        if (bm.in_ready !== 1'b0 || bm.out_valid !== 1'b1 || bm.out_read !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b read=%b, need 0 1 1",
                     bm.in_ready, bm.out_valid, bm.out_read);
        end
        @(negedge clk);
        checks++;
        if (bm.in_ready !== 1'b0 || bm.out_read !== 1'b1 || bm.out_opcode !== 8'h08) begin
            errors++;
            $display("FAIL bp_hold: in_ready=%b read=%b op=%h, need 0 1 08",
                     bm.in_ready, bm.out_read, bm.out_opcode);
        end
        drive(1'b1, 32'h0000_0005, 1'b1);
        @(negedge clk);
        checks++;
        if (bm.out_atomic !== 7'b0000010 || bm.out_read !== 1'b0 || bm.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: atomic=%b read=%b in_ready=%b, need 0000010 0 1",
                     bm.out_atomic, bm.out_read, bm.in_ready);
        end
        @(negedge clk);
        drive(1'b0, 'x, 1'b1);
        checks++;
        if (bm.out_write_ack !== 1'b1 || bm.out_valid !== 1'b1 || bm.out_atomic !== 7'd0) begin
            errors++;
            $display("FAIL bp_third: write_ack=%b valid=%b atomic=%b, need 1 1 0",
                     bm.out_write_ack, bm.out_valid, bm.out_atomic);
        end
        @(negedge clk);
        checks++;
        if (bm.out_valid !== 1'b0 || m_cr !== 16'd1 || m_ca !== 16'd1 || m_cw !== 16'd1) begin
            errors++;
            $display("FAIL bp_drain: valid=%b wr=%0d rd=%0d at=%0d, need 0 1 1 1",
                     bm.out_valid, m_cw, m_cr, m_ca);
        end
    endtask

    task automatic test_stream();
        logic [7:0]  pat [8];
        logic [31:0] cmds [100];
        int          bad_ready;
        int          bad_order;
        pat = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h39, 8'h69, 8'hFF, 8'h05};
        bad_ready = 0;
        bad_order = 0;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            cmds[k] = {20'(k * 3 + 1), 4'(k), pat[k % 8]};
            drive(1'b1, cmds[k], 1'b1);
            if (bm.in_ready !== 1'b1) bad_ready++;
            if (k > 0 && {bm.out_valid, bm.out_user, bm.out_length, bm.out_opcode} !==
                         {1'b1, cmds[k-1]}) bad_order++;
            @(negedge clk);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++;
            $display("FAIL stream_ready: in_ready low in %0d cycles, need 0", bad_ready);
        end
        checks++;
        if (bad_order != 0) begin
            errors++;
            $display("FAIL stream_order: %0d head mismatches, need 0", bad_order);
        end
        checks++;
        if ({bm.out_valid, bm.out_user, bm.out_length, bm.out_opcode} !== {1'b1, cmds[99]}) begin
            errors++;
            $display("FAIL stream_last: head=%h%h%h, need %h",
                     bm.out_user, bm.out_length, bm.out_opcode, cmds[99]);
        end
        drive(1'b0, 'x, 1'b1);
        @(negedge clk);
        checks++;
        if (m_cw !== 16'd38 || m_cr !== 16'd13 || m_ca !== 16'd37 || m_ci !== 16'd12 ||
            bm.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_cnt: wr=%0d rd=%0d at=%0d il=%0d v=%b, need 38 13 37 12 0",
                     m_cw, m_cr, m_ca, m_ci, bm.out_valid);
        end
        checks++;
        if (d_cw !== 16'd38 || d_cr !== 16'd13 || d_ca !== 16'd37 || d_ci !== 16'd12) begin
            errors++;
            $display("FAIL stream_cnt_drop: wr=%0d rd=%0d at=%0d il=%0d, need 38 13 37 12",
                     d_cw, d_cr, d_ca, d_ci);
        end
        checks++;
        if (s_cw !== 4'd15 || s_cr !== 4'd13 || s_ca !== 4'd15 || s_ci !== 4'd12) begin
            errors++;
            $display("FAIL stream_cnt_sat: wr=%0d rd=%0d at=%0d il=%0d, need 15 13 15 12",
                     s_cw, s_cr, s_ca, s_ci);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1'b1, 32'h0000_0101, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h0000_02FF, 1'b1);
        checks++;
        if (bm.out_write !== 1'b1 || bd.out_write !== 1'b1 || bd.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ill_first: main wr=%b drop wr=%b drop v=%b, need 1 1 1",
                     bm.out_write, bd.out_write, bd.out_valid);
        end
        @(negedge clk);
        drive(1'b1, 32'h0000_0301, 1'b1);
        checks++;
        if (bm.out_valid !== 1'b1 || bm.out_illegal !== 1'b1 || bm.out_write !== 1'b0 ||
            bm.out_atomic !== 7'd0 || bm.out_read !== 1'b0 || bm.out_opcode !== 8'hFF) begin
            errors++;
            $display("FAIL ill_forward: v=%b ill=%b wr=%b at=%b rd=%b op=%h, need 1 1 0 0 0 ff",
                     bm.out_valid, bm.out_illegal, bm.out_write, bm.out_atomic, bm.out_read,
                     bm.out_opcode);
        end
        checks++;
        if (bd.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ill_drop: drop out_valid=%b, need 0", bd.out_valid);
        end
        @(negedge clk);
        drive(1'b0, 'x, 1'b1);
        checks++;
        if (bd.out_valid !== 1'b1 || bd.out_write !== 1'b1 || bd.out_length !== 4'd3 ||
            bm.out_length !== 4'd3) begin
            errors++;
            $display("FAIL ill_last: drop v=%b wr=%b len=%h main len=%h, need 1 1 3 3",
                     bd.out_valid, bd.out_write, bd.out_length, bm.out_length);
        end
        @(negedge clk);
        checks++;
        if (d_ci !== 16'd1 || d_cw !== 16'd2 || m_ci !== 16'd1 || m_cw !== 16'd2) begin
            errors++;
            $display("FAIL ill_cnt: drop il=%0d wr=%0d main il=%0d wr=%0d, need 1 2 1 2",
                     d_ci, d_cw, m_ci, m_cw);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h0000_0008, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 'x, 1'b1);
        @(negedge clk);
        checks++;
        if (s_cr !== 4'd15 || m_cr !== 16'd20) begin
            errors++;
            $display("FAIL sat_read: sat=%0d main=%0d, need 15 20", s_cr, m_cr);
        end
        drive(1'b1, 32'h0000_0008, 1'b1);
        @(negedge clk);
        drive(1'b0, 'x, 1'b1);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        checks++;
        if (s_cr !== 4'd0 || m_cr !== 16'd0 || bm.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins: sat=%0d main=%0d v=%b, need 0 0 0", s_cr, m_cr, bm.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        do_reset();
        drive(1'b1, 32'h0000_0001, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h0000_0008, 1'b0);
        @(negedge clk);
        drive(1'b0, 'x, 1'b0);
        checks++;
        if (bm.in_ready !== 1'b0 || bm.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: in_ready=%b out_valid=%b, need 0 1", bm.in_ready, bm.out_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bm.out_valid !== 1'b0 || bm.in_ready !== 1'b0 || bm.out_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: out_valid=%b in_ready=%b wr=%b, need 0 0 0",
                     bm.out_valid, bm.in_ready, bm.out_write);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 'x, 1'b1);
        @(negedge clk);
        checks++;
        if (bm.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready: in_ready=%b after release edge, need 1", bm.in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            if (bm.out_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || m_cw !== 16'd0 || m_cr !== 16'd0) begin
            errors++;
            $display("FAIL mid_replay: valid seen %0d cycles wr=%0d rd=%0d, need 0 0 0",
                     seen, m_cw, m_cr);
        end
    endtask

    initial begin
        drive(1'b0, 'x, 1'b0);
        test_reset();
        test_single();
        test_back_to_back();
        test_stream();
        test_illegal();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
